// File: rtl/calc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : calc_controller
//  Purpose  : Sequencing controller for the lab calculator. Synchronizes and
//             debounces the raw add pushbutton, runs the ID/calculator mode
//             FSM, owns the 4-bit two's-complement accumulator with its
//             overflow flag, and schedules the four multiplexed SSD digits.
//  Ports    : Clk        - system clock, rising edge
//             reset      - synchronous, active-high
//             add        - raw pushbutton, asynchronous to Clk
//             data_in    - 4-bit two's-complement operand (switches)
//             id_in      - four BCD digits shown in ID mode, [15:12] leftmost
//             sum        - accumulator, two's complement
//             overflow   - signed overflow of the most recent accepted add
//             add_pulse  - one-cycle strobe per accepted press
//             calc_mode  - 0 = ID mode, 1 = calculator mode
//             AN         - digit anodes, active-low, one-cold
//             digit      - SSD code: 0-15 hex, 16 = minus, 17 = blank
//  Revision : 1.0 - initial release
// ============================================================================
module calc_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 100000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        add,
    input  logic [3:0]  data_in,
    input  logic [15:0] id_in,
    output logic [3:0]  sum,
    output logic        overflow,
    output logic        add_pulse,
    output logic        calc_mode,
    output logic [3:0]  AN,
    output logic [4:0]  digit
);

    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [c_DB_W-1:0]   c_db_last   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_SCAN_W-1:0] c_scan_last = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [4:0]          c_dig_minus = 5'd16;
    localparam logic [4:0]          c_dig_blank = 5'd17;

    typedef enum logic [1:0] {
        BTN_IDLE       = 2'd0,
        BTN_PRESS_WAIT = 2'd1,
        BTN_HELD       = 2'd2,
        BTN_REL_WAIT   = 2'd3
    } btn_state_t;

    typedef enum logic [0:0] {
        MODE_ID   = 1'b0,
        MODE_CALC = 1'b1
    } mode_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous button
    // ------------------------------------------------------------------
    logic r_add_meta;
    logic r_add_s;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_add_meta <= 1'b0;
            r_add_s    <= 1'b0;
        end else begin
            r_add_meta <= add;
            r_add_s    <= r_add_meta;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce FSM
    // ------------------------------------------------------------------
    btn_state_t         r_btn_state;
    btn_state_t         w_btn_next;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [c_DB_W-1:0]  w_db_cnt_next;
    logic               r_add_pulse;
    logic               w_pulse_next;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_btn_state <= BTN_IDLE;
            r_db_cnt    <= '0;
            r_add_pulse <= 1'b0;
        end else begin
            r_btn_state <= w_btn_next;
            r_db_cnt    <= w_db_cnt_next;
            r_add_pulse <= w_pulse_next;
        end
    end

    always_comb begin
        w_btn_next    = r_btn_state;
        w_db_cnt_next = r_db_cnt;
        w_pulse_next  = 1'b0;
        case (r_btn_state)
            BTN_IDLE: begin
                if (r_add_s) begin
                    w_db_cnt_next = '0;
                    w_btn_next    = BTN_PRESS_WAIT;
                end
            end
            BTN_PRESS_WAIT: begin
                if (!r_add_s) begin
                    w_btn_next = BTN_IDLE;
                end else if (r_db_cnt == c_db_last) begin
                    w_pulse_next = 1'b1;
                    w_btn_next   = BTN_HELD;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            BTN_HELD: begin
                if (!r_add_s) begin
                    w_db_cnt_next = '0;
                    w_btn_next    = BTN_REL_WAIT;
                end
            end
            BTN_REL_WAIT: begin
                // Any 1 during the release window means the contact bounced
                // back closed; the press is still the same one.
                if (r_add_s) begin
                    w_btn_next = BTN_HELD;
                end else if (r_db_cnt == c_db_last) begin
                    w_btn_next = BTN_IDLE;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_btn_next    = BTN_IDLE;
                w_db_cnt_next = '0;
            end
        endcase
    end

    assign add_pulse = r_add_pulse;

    // ------------------------------------------------------------------
    // Mode FSM and accumulator
    // ------------------------------------------------------------------
    mode_state_t r_mode;
    mode_state_t w_mode_next;
    logic [3:0]  r_sum;
    logic [3:0]  w_sum_next;
    logic        r_ovf;
    logic        w_ovf_next;
    logic [3:0]  w_sum_add;

    assign w_sum_add = r_sum + data_in;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_mode <= MODE_ID;
            r_sum  <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_mode <= w_mode_next;
            r_sum  <= w_sum_next;
            r_ovf  <= w_ovf_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        w_sum_next  = r_sum;
        w_ovf_next  = r_ovf;
        if (r_add_pulse) begin
            case (r_mode)
                MODE_ID: begin
                    // First press only leaves the ID screen.
                    w_mode_next = MODE_CALC;
                end
                MODE_CALC: begin
                    w_sum_next = w_sum_add;
                    // Signed overflow: like-signed operands, result sign flips.
                    w_ovf_next = (r_sum[3] == data_in[3]) && (w_sum_add[3] != r_sum[3]);
                end
                default: begin
                    w_mode_next = MODE_ID;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign overflow  = r_ovf;
    assign calc_mode = (r_mode == MODE_CALC);

    // ------------------------------------------------------------------
    // Display scan: one-cold anode ring advanced every SCAN_DIV cycles
    // ------------------------------------------------------------------
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [3:0]          r_an;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_an       <= 4'b1110;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_an       <= {r_an[2:0], r_an[3]};
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign AN = r_an;

    // Magnitude of the signed sum; -8 negates to itself and reads as 8.
    logic [3:0] w_mag;
    assign w_mag = r_sum[3] ? (~r_sum + 4'd1) : r_sum;

    always_comb begin
        digit = c_dig_blank;
        if (r_mode == MODE_ID) begin
            case (r_an)
                4'b1110: digit = {1'b0, id_in[3:0]};
                4'b1101: digit = {1'b0, id_in[7:4]};
                4'b1011: digit = {1'b0, id_in[11:8]};
                4'b0111: digit = {1'b0, id_in[15:12]};
                default: digit = c_dig_blank;
            endcase
        end else begin
            case (r_an)
                4'b1110: digit = {1'b0, w_mag};
                4'b1101: digit = r_sum[3] ? c_dig_minus : c_dig_blank;
                default: digit = c_dig_blank;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/calc_controller.md
# calc_controller

Sequencing controller for the lab calculator. It synchronizes and debounces the raw `add` pushbutton and runs the mode FSM (ID display → calculator). It owns the 4-bit two's-complement accumulator and its overflow flag, and schedules the four multiplexed seven-segment digits. It sits between the board I/O (buttons, switches) and the per-digit SSD decoders, replacing the free-running divider/ring-counter glue with one synchronous-reset block.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz).
- `SCAN_DIV`, default 100000: `Clk` cycles per digit-scan step (500 Hz at 50 MHz).

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `add`  in  1  raw pushbutton, asynchronous to `Clk`.
- `data_in`  in  4  two's-complement operand (switches).
- `id_in`  in  16  four BCD digits shown in ID mode; `[15:12]` is leftmost.
- `sum`  out  4  accumulator, two's complement.
- `overflow`  out  1  signed overflow of the most recent accepted add.
- `add_pulse`  out  1  one-cycle strobe per accepted press.
- `calc_mode`  out  1  0 = ID mode, 1 = calculator mode.
- `AN`  out  4  digit anodes, active-low, exactly one bit low.
- `digit`  out  5  code for the SSD decoder: 0–15 hex, 16 = minus sign, 17 = blank.

## Operation
Input synchronizer:
- `add` passes through two flops to form `add_s`. Only `add_s` is used internally.

Button FSM (`BTN_IDLE`, `BTN_PRESS_WAIT`, `BTN_HELD`, `BTN_REL_WAIT`):
- `BTN_IDLE`: on `add_s`=1, clear the debounce counter and go to `BTN_PRESS_WAIT`.
- `BTN_PRESS_WAIT`: if `add_s`=0, return to `BTN_IDLE`. Once the counter reaches `DEBOUNCE_CYCLES`-1 with `add_s` still 1, assert `add_pulse` for one cycle and go to `BTN_HELD`.
- `BTN_HELD`: on `add_s`=0, clear the counter and go to `BTN_REL_WAIT`.
- `BTN_REL_WAIT`: if `add_s`=1, return to `BTN_HELD`. After `DEBOUNCE_CYCLES` consecutive 0s, go to `BTN_IDLE`.
- Holding the button yields exactly one `add_pulse`. Bounce shorter than `DEBOUNCE_CYCLES` yields none.

Mode FSM (`MODE_ID`, `MODE_CALC`):
- On `add_pulse` in `MODE_ID`: go to `MODE_CALC`. `sum` and `overflow` are not modified.
- On `add_pulse` in `MODE_CALC`:
  - `sum <= sum + data_in` (mod 16).
  - `overflow <= 1` iff `sum[3]==data_in[3]` and the new sum's bit 3 differs; otherwise `overflow <= 0`. The flag is not sticky.
- `MODE_CALC` is left only by `reset`.

Display scheduler:
- A scan counter counts 0..`SCAN_DIV`-1. At the terminal count it wraps to 0 and `AN` rotates 1110 → 1101 → 1011 → 0111 → 1110.
- `digit` is combinational from `AN` and mode.
- In ID mode: `AN[0]` low → `id_in[3:0]`, `AN[1]` → `[7:4]`, `AN[2]` → `[11:8]`, `AN[3]` → `[15:12]`.
- In calculator mode:
  - `AN[0]` → magnitude of `sum` (0–8; -8 shows 8).
  - `AN[1]` → 16 if `sum[3]`, else 17.
  - `AN[2]` and `AN[3]` → 17.

## Timing
- Reset values: `sum`=0, `overflow`=0, `add_pulse`=0, `calc_mode`=0, `AN`=4'b1110, scan counter=0, button FSM=`BTN_IDLE`, synchronizer flops=0.
- `reset` held high for one edge restores all of the above, including mid-debounce and mid-scan. A press in progress when reset is asserted is discarded. A button held through reset release produces a new pulse only after `DEBOUNCE_CYCLES` stable cycles measured after reset.
- Press latency from the `add` rising edge to `add_pulse`: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 cycle.
- `sum`, `overflow` and `calc_mode` update on the edge where `add_pulse` is high; they are visible the next cycle.
- `data_in` is sampled on that same edge; it has no other timing requirement.
- `AN` changes every `SCAN_DIV` cycles; the first change occurs `SCAN_DIV` cycles after reset deasserts.
- `digit` tracks `AN` and `sum` within the same cycle (no extra latency).

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `SCAN_DIV`=3.
- Reset, then hold `add`=0 → `AN` sequence 1110, 1101, 1011, 0111, 1110 at 3-cycle intervals; with `id_in`=16'h3515, `digit` reads 5, 1, 5, 3.
- Drive `add` high for 3 cycles, low, then high for 20 cycles → exactly one `add_pulse`, 7 cycles after the second rise; `calc_mode` becomes 1 and `sum` stays 0.
- In calculator mode, `data_in`=4'h5 then two clean presses → `sum`=5 with `overflow`=0, then `sum`=4'hA with `overflow`=1; the display shows `-` and 6.
- `sum`=4'h8, `data_in`=4'hF, one press → `sum`=4'h7, `overflow`=1. A following press with `data_in`=4'h1 → `sum`=4'h8, `overflow`=1. With `data_in`=4'h0 → `overflow`=0.
- Assert `reset` for one cycle during `BTN_PRESS_WAIT` and during `MODE_CALC` → all outputs return to their reset values; no `add_pulse` is produced.
- Hold `add` high across reset deassertion → one `add_pulse` at 2+4+1 cycles after reset deasserts; none afterward until a release and a new press.
